traffic_light_ctrl: RTL and testbench

Phase sequencer for the traffic-light datapath. It consumes the red and green wait times fetched from the register file, together with a configuration-valid level. It then drives the RED → GREEN → YELLOW → RED light cycle using a per-second tick prescaler. It sits downstream of the register-file read logic and directly drives the lamp outputs.

---
 rtl/traffic_light_ctrl.sv | 146 ++++++++++++++
 tb/tb_traffic_light_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_ctrl.sv
// Traffic-light phase sequencer: RED -> GREEN -> YELLOW -> RED paced by a tick prescaler.
// Optional pedestrian GREEN shortening is compiled in with `define PED_REQ_EN.
module traffic_light_ctrl #(
  parameter int         TICK_DIV = 50_000_000,
  parameter logic [2:0] Y_WAIT   = 3'd2
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       cfg_valid,
  input  logic [2:0] t_r_wait,
  input  logic [2:0] t_g_wait,
`ifdef PED_REQ_EN
  input  logic       ped_req,
  output logic       ped_ack,
`endif
  output logic       light_r,
  output logic       light_y,
  output logic       light_g,
  output logic [1:0] state,
  output logic [2:0] remain
);

  localparam int             PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  TICK_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RED    = 2'd1,
    S_GREEN  = 2'd2,
    S_YELLOW = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    remain_q, remain_d;
  logic          light_r_q, light_r_d;
  logic          light_y_q, light_y_d;
  logic          light_g_q, light_g_d;
  logic          tick;

  // A zero wait still gives a one-tick phase.
  function automatic logic [2:0] phase_len(input logic [2:0] w);
    return (w == 3'd0) ? 3'd1 : w;
  endfunction

`ifdef PED_REQ_EN
  logic ped_s1_q, ped_s2_q;
  logic ped_ack_q, ped_ack_d;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ped_s1_q  <= 1'b0;
      ped_s2_q  <= 1'b0;
      ped_ack_q <= 1'b0;
    end else begin
      ped_s1_q  <= ped_req;
      ped_s2_q  <= ped_s1_q;
      ped_ack_q <= ped_ack_d;
    end
  end

  assign ped_ack = ped_ack_q;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      remain_q  <= 3'd0;
      light_r_q <= 1'b1;
      light_y_q <= 1'b0;
      light_g_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      remain_q  <= remain_d;
      light_r_q <= light_r_d;
      light_y_q <= light_y_d;
      light_g_q <= light_g_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    remain_d = remain_q;
`ifdef PED_REQ_EN
    ped_ack_d = 1'b0;
`endif
    tick = (state_q != S_IDLE) && (presc_q == TICK_LAST);

    if (state_q == S_IDLE) begin
      presc_d = '0;
      if (cfg_valid) begin
        state_d  = S_RED;
        remain_d = phase_len(t_r_wait);
      end
    end else begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (tick && (remain_q == 3'd1)) begin
        // Phase entry: wait inputs are sampled here only; prescaler restarts.
        presc_d = '0;
        case (state_q)
          S_RED: begin
            state_d  = S_GREEN;
            remain_d = phase_len(t_g_wait);
          end
          S_GREEN: begin
            state_d  = S_YELLOW;
            remain_d = phase_len(Y_WAIT);
          end
          default: begin
            state_d  = S_RED;
            remain_d = phase_len(t_r_wait);
          end
        endcase
      end
`ifdef PED_REQ_EN
      // Shortening leaves the prescaler alone so GREEN ends on the next tick.
      else if (ped_s2_q && (state_q == S_GREEN) && (remain_q > 3'd1)) begin
        remain_d  = 3'd1;
        ped_ack_d = 1'b1;
      end
`endif
      else if (tick) begin
        remain_d = remain_q - 3'd1;
      end
    end

    light_r_d = 1'b0;
    light_y_d = 1'b0;
    light_g_d = 1'b0;
    case (state_d)
      S_GREEN:  light_g_d = 1'b1;
      S_YELLOW: light_y_d = 1'b1;
      default:  light_r_d = 1'b1;
    endcase
  end

  assign state   = state_q;
  assign remain  = remain_q;
  assign light_r = light_r_q;
  assign light_y = light_y_q;
  assign light_g = light_g_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl (TICK_DIV=4, Y_WAIT=2); pedestrian checks build with PED_REQ_EN.
module tb_traffic_light_ctrl;

  localparam int         TD = 4;
  localparam logic [2:0] YW = 3'd2;
  localparam logic [7:0] RESET_EXP = {2'd0, 3'b100, 3'd0};

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [2:0] t_r_wait = 3'd0;
  logic [2:0] t_g_wait = 3'd0;
  logic       ped_req = 1'b0;
  logic       light_r, light_y, light_g;
  logic [1:0] state;
  logic [2:0] remain;
`ifdef PED_REQ_EN
  logic       ped_ack;
`endif

  traffic_light_ctrl #(.TICK_DIV(TD), .Y_WAIT(YW)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .cfg_valid (cfg_valid),
    .t_r_wait  (t_r_wait),
    .t_g_wait  (t_g_wait),
`ifdef PED_REQ_EN
    .ped_req   (ped_req),
    .ped_ack   (ped_ack),
`endif
    .light_r   (light_r),
    .light_y   (light_y),
    .light_g   (light_g),
    .state     (state),
    .remain    (remain)
  );

  // clock / reset
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: phase number, phase length in ticks, cycles elapsed since entry.
  int   m_ph, m_n, m_el;
  logic m_p1, m_p2, m_ack;

  logic [7:0] obs, expv;
  logic [7:0] dur_q[$];
  logic [7:0] exp_q[$];
  logic [1:0] prev_st;
  int         run_len;

  function automatic int wait_of(input int p);
    int w;
    w = (p == 1) ? int'(t_r_wait) : (p == 2) ? int'(t_g_wait) : int'(YW);
    return (w == 0) ? 1 : w;
  endfunction

  function automatic int m_remain();
    return (m_ph == 0) ? 0 : m_n - m_el / TD;
  endfunction

  function automatic logic [7:0] m_expect();
    logic [2:0] lamps;
    int r;
    lamps = (m_ph == 2) ? 3'b001 : (m_ph == 3) ? 3'b010 : 3'b100;
    r = m_remain();
    return {m_ph[1:0], lamps, r[2:0]};
  endfunction

  task automatic m_reset();
    m_ph = 0; m_n = 0; m_el = 0;
    m_p1 = 1'b0; m_p2 = 1'b0; m_ack = 1'b0;
  endtask

  task automatic m_enter(input int p);
    m_ph = p;
    m_n  = wait_of(p);
    m_el = 0;
  endtask

  task automatic track_reset();
    dur_q.delete();
    exp_q.delete();
    prev_st = 2'd0;
    run_len = 0;
  endtask

  // driver: one clock, model advanced at the edge, outputs captured on the falling edge
  task automatic cycle();
    logic old_p2;
    int   rem_before;
    @(posedge clk);
    if (!n_rst) begin
      m_reset();
    end else begin
      old_p2 = m_p2;
      m_p2   = m_p1;
      m_p1   = ped_req;
      m_ack  = 1'b0;
      if (m_ph == 0) begin
        if (cfg_valid) m_enter(1);
      end else begin
        rem_before = m_remain();
        m_el++;
        if (m_el >= m_n * TD) m_enter((m_ph == 3) ? 1 : m_ph + 1);
        else if (old_p2 && m_ph == 2 && rem_before > 1) begin
          m_n   = m_el / TD + 1;
          m_ack = 1'b1;
        end
      end
    end
    @(negedge clk);
    obs  = {state, light_r, light_y, light_g, remain};
    expv = m_expect();
    if (state == prev_st) run_len++;
    else begin
      if (prev_st != 2'd0) dur_q.push_back(8'(run_len));
      prev_st = state;
      run_len = 1;
    end
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    cfg_valid = 1'b0;
    m_reset();
    repeat (2) cycle();
    n_rst = 1'b1;
    track_reset();
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    cfg_valid = 1'b0;
    m_reset();
    for (int i = 0; i < 20; i++) begin
      cycle();
      vectors++;
      if (obs !== RESET_EXP) begin
        miscompares++;
        $display("FAIL reset cyc %0d: got %b want %b (state,rgy,remain)", i, obs, RESET_EXP);
      end
    end
    n_rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      vectors++;
      if (obs !== RESET_EXP) begin
        miscompares++;
        $display("FAIL idle_no_cfg cyc %0d: got %b want %b", i, obs, RESET_EXP);
      end
    end
  endtask

  task automatic test_basic_cycle();
    int sum;
    do_reset();
    t_r_wait = 3'd2;
    t_g_wait = 3'd3;
    cfg_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cycle();
      vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("FAIL basic cyc %0d: got %b want %b", i, obs, expv);
      end
    end
    exp_q = '{8'd8, 8'd12, 8'd8, 8'd8};
    sum = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (i >= dur_q.size() || dur_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL basic_dur %0d: got %0d want %0d", i, (i < dur_q.size()) ? dur_q[i] : 8'd0, exp_q[i]);
      end else if (i < 3) sum += int'(dur_q[i]);
    end
    vectors++;
    if (sum !== 28) begin
      miscompares++;
      $display("FAIL basic_period: got %0d want 28", sum);
    end
  endtask

  task automatic test_zero_and_max();
    do_reset();
    t_r_wait = 3'd7;
    t_g_wait = 3'd0;
    cfg_valid = 1'b1;
    for (int i = 0; i < 44; i++) begin
      cycle();
      vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("FAIL zero_max cyc %0d: got %b want %b", i, obs, expv);
      end
    end
    exp_q = '{8'd28, 8'd4, 8'd8};
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (i >= dur_q.size() || dur_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL zero_max_dur %0d: got %0d want %0d", i, (i < dur_q.size()) ? dur_q[i] : 8'd0, exp_q[i]);
      end
    end
  endtask

  task automatic test_midphase_change();
    do_reset();
    t_r_wait = 3'd2;
    t_g_wait = 3'd3;
    cfg_valid = 1'b1;
    for (int i = 0; i < 54; i++) begin
      if (i == 3) t_r_wait = 3'd5;
      if (i == 10) cfg_valid = 1'b0;
      cycle();
      vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("FAIL midphase cyc %0d: got %b want %b", i, obs, expv);
      end
    end
    exp_q = '{8'd8, 8'd12, 8'd8, 8'd20};
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (i >= dur_q.size() || dur_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL midphase_dur %0d: got %0d want %0d", i, (i < dur_q.size()) ? dur_q[i] : 8'd0, exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_midgreen();
    int i;
    do_reset();
    t_r_wait = 3'd1;
    t_g_wait = 3'd3;
    cfg_valid = 1'b1;
    i = 0;
    while (i < 100 && !(m_ph == 2 && m_remain() == 2)) begin
      cycle();
      i++;
    end
    vectors++;
    if (!(m_ph == 2 && m_remain() == 2)) begin
      miscompares++;
      $display("FAIL midgreen_wait: got timeout want GREEN remain=2");
    end
    #2;
    n_rst = 1'b0;
    m_reset();
    #1;
    obs = {state, light_r, light_y, light_g, remain};
    vectors++;
    if (obs !== RESET_EXP) begin
      miscompares++;
      $display("FAIL midgreen_async: got %b want %b", obs, RESET_EXP);
    end
    cycle();
    n_rst = 1'b1;
    for (int k = 0; k < 16; k++) begin
      cycle();
      vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("FAIL midgreen_resume cyc %0d: got %b want %b", k, obs, expv);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) t_r_wait = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) t_g_wait = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) cfg_valid = ~cfg_valid;
      if ($urandom_range(0, 199) == 0) begin
        n_rst = 1'b0;
        m_reset();
      end else n_rst = 1'b1;
      cycle();
      vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("FAIL random cyc %0d: got %b want %b", i, obs, expv);
      end
    end
    n_rst = 1'b1;
  endtask

`ifdef PED_REQ_EN
  task automatic test_ped();
    int i, acks;
    do_reset();
    t_r_wait = 3'd1;
    t_g_wait = 3'd5;
    cfg_valid = 1'b1;
    i = 0;
    while (i < 100 && !(m_ph == 2 && m_remain() == 3)) begin
      cycle();
      i++;
    end
    vectors++;
    if (!(m_ph == 2 && m_remain() == 3)) begin
      miscompares++;
      $display("FAIL ped_wait: got timeout want GREEN remain=3");
    end
    ped_req = 1'b1;
    acks = 0;
    for (int k = 0; k < 40; k++) begin
      if (k == 20) ped_req = 1'b0;
      cycle();
      if (ped_ack === 1'b1 && m_ph == 2) acks++;
      vectors++;
      if (obs !== expv || ped_ack !== m_ack) begin
        miscompares++;
        $display("FAIL ped cyc %0d: got %b ack %b want %b ack %b", k, obs, ped_ack, expv, m_ack);
      end
    end
    vectors++;
    if (acks !== 1) begin
      miscompares++;
      $display("FAIL ped_ack_count: got %0d want 1", acks);
    end
  endtask
`endif

  initial begin
    m_reset();
    track_reset();
    test_reset();
    test_basic_cycle();
    test_zero_and_max();
    test_midphase_change();
    test_reset_midgreen();
`ifdef PED_REQ_EN
    test_ped();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
